shot_manager: RTL and testbench

//   Owns the projectile table feeding the draw controller and the collision logic.

---
 rtl/asteroids_pkg.sv | 34 +++
 rtl/shot_velocity_lut.sv | 18 +
 rtl/shot_manager.sv | 73 +++++++
 tb/tb_shot_manager.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/asteroids_pkg.sv
// asteroids_pkg: entity word layout, screen geometry and direction codes shared by game logic
package asteroids_pkg;
  localparam int ENTITY_SIZE = 34;
  localparam int ALIVE_BIT = 33;
  localparam int X_MSB = 32;
  localparam int X_LSB = 23;
  localparam int Y_MSB = 22;
  localparam int Y_LSB = 13;
  localparam int DIR_MSB = 12;
  localparam int DIR_LSB = 7;
  localparam int TTL_MSB = 6;
  localparam int TTL_LSB = 0;
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  // 6-bit heading, 5.625 degree steps, 0 = up, increasing clockwise
  localparam logic [5:0] DIR_UP = 6'd0;
  localparam logic [5:0] DIR_RIGHT = 6'd16;
  localparam logic [5:0] DIR_DOWN = 6'd32;
  localparam logic [5:0] DIR_LEFT = 6'd48;
  typedef struct packed {
    logic       alive;
    logic [9:0] x;
    logic [9:0] y;
    logic [5:0] dir;
    logic [6:0] ttl;
  } entity_t;
  function automatic logic [9:0] wrap_add(input logic [9:0] p, input logic signed [2:0] d,
                                          input logic [9:0] m);
    logic signed [10:0] s, ms;
    s = $signed({1'b0, p}) + $signed({{8{d[2]}}, d});
    ms = $signed({1'b0, m});
    return s < 0 ? 10'(s + ms) : s >= ms ? 10'(s - ms) : 10'(s);
  endfunction
endpackage

// File: rtl/shot_velocity_lut.sv
// shot_velocity_lut: heading code to per-tick signed displacement (dx, dy), screen y grows downward
module shot_velocity_lut (
  input  logic        [5:0] dir_i,
  output logic signed [2:0] dx_o,
  output logic signed [2:0] dy_o
);
  logic signed [2:0] s, c;
  // rounded 2*sin of the angle within a quadrant, indexed 0..16
  function automatic logic signed [2:0] mag(input logic [4:0] n);
    return n < 5'd3 ? 3'sd0 : n < 5'd9 ? 3'sd1 : 3'sd2;
  endfunction
  always_comb begin
    s = mag({1'b0, dir_i[3:0]});
    c = mag(5'd16 - {1'b0, dir_i[3:0]});
    dx_o = dir_i[5:4] == 2'd0 ? s : dir_i[5:4] == 2'd1 ? c : dir_i[5:4] == 2'd2 ? -s : -c;
    dy_o = dir_i[5:4] == 2'd0 ? -c : dir_i[5:4] == 2'd1 ? s : dir_i[5:4] == 2'd2 ? c : -s;
  end
endmodule

// File: rtl/shot_manager.sv
// shot_manager: projectile table with spawn on fire, per-tick aging/movement with screen wrap, and kills
module shot_manager
  import asteroids_pkg::*;
#(
  parameter int MAX_SHOTS = 10,
  parameter int SHOT_TTL  = 90,
  parameter int COOLDOWN  = 8
) (
  input  logic                             move_clk,
  input  logic                             reset_n,
  input  logic                             fire_req,
  input  logic [9:0]                       ship_x,
  input  logic [9:0]                       ship_y,
  input  logic [5:0]                       ship_dir,
  input  logic [MAX_SHOTS-1:0]             kill_mask,
  output logic [MAX_SHOTS*ENTITY_SIZE-1:0] shots,
  output logic                             fire_ack,
  output logic                             fire_drop,
  output logic [3:0]                       shot_count
);
  localparam int IW = $clog2(MAX_SHOTS);
  entity_t [MAX_SHOTS-1:0] slot_q, slot_d;
  logic signed [2:0] dx [MAX_SHOTS];
  logic signed [2:0] dy [MAX_SHOTS];
  logic [7:0] cd_q, cd_d;
  logic ack_q, ack_d, drop_q, drop_d, any_free, accept;
  logic [3:0] cnt_q, cnt_d;
  logic [IW-1:0] tgt;
  for (genvar i = 0; i < MAX_SHOTS; i++) begin : g_slot
    shot_velocity_lut u_lut (.dir_i(slot_q[i].dir), .dx_o(dx[i]), .dy_o(dy[i]));
  end
  always_comb begin
    slot_d = '0;
    any_free = 1'b0;
    tgt = '0;
    cnt_d = '0;
    for (int i = 0; i < MAX_SHOTS; i++)
      if (slot_q[i].alive && !kill_mask[i] && slot_q[i].ttl != 7'd1)
        slot_d[i] = '{1'b1, wrap_add(slot_q[i].x, dx[i], 10'(SCREEN_W)),
                      wrap_add(slot_q[i].y, dy[i], 10'(SCREEN_H)), slot_q[i].dir,
                      slot_q[i].ttl - 7'd1};
    // eligibility uses pre-edge liveness, so slots freed this edge cannot be reused yet
    for (int i = MAX_SHOTS - 1; i >= 0; i--)
      if (!slot_q[i].alive) begin
        any_free = 1'b1;
        tgt = IW'(i);
      end
    accept = fire_req && cd_q == 8'd0;
    ack_d = accept && any_free;
    drop_d = accept && !any_free;
    if (ack_d) slot_d[tgt] = '{1'b1, ship_x, ship_y, ship_dir, 7'(SHOT_TTL)};
    cd_d = ack_d ? 8'(COOLDOWN) : cd_q != 8'd0 ? cd_q - 8'd1 : cd_q;
    for (int i = 0; i < MAX_SHOTS; i++) cnt_d = cnt_d + 4'(slot_d[i].alive);
  end
  always_ff @(posedge move_clk or posedge reset_n)
    if (reset_n) begin
      slot_q <= '0;
      cd_q <= '0;
      ack_q <= 1'b0;
      drop_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      slot_q <= slot_d;
      cd_q <= cd_d;
      ack_q <= ack_d;
      drop_q <= drop_d;
      cnt_q <= cnt_d;
    end
  assign shots = slot_q;
  assign fire_ack = ack_q;
  assign fire_drop = drop_q;
  assign shot_count = cnt_q;
endmodule

// File: tb/tb_shot_manager.sv
// tb_shot_manager: directed checks of spawn, movement, wrap, cooldown, drop, lifetime and async reset
module tb_shot_manager;
  logic move_clk = 1'b0, reset_n = 1'b1, fire_req = 1'b0;
  logic [9:0] ship_x = '0, ship_y = '0, kill_mask = '0;
  logic [5:0] ship_dir = '0;
  logic [339:0] shots_a, shots_l, shots_s;
  logic ack_a, ack_l, ack_s, drop_a, drop_l, drop_s;
  logic [3:0] cnt_a, cnt_l, cnt_s;
  int checks = 0, failures = 0;

  shot_manager dut_a (.move_clk(move_clk), .reset_n(reset_n), .fire_req(fire_req), .ship_x(ship_x),
    .ship_y(ship_y), .ship_dir(ship_dir), .kill_mask(kill_mask), .shots(shots_a),
    .fire_ack(ack_a), .fire_drop(drop_a), .shot_count(cnt_a));
  shot_manager #(.SHOT_TTL(127)) dut_l (.move_clk(move_clk), .reset_n(reset_n), .fire_req(fire_req),
    .ship_x(ship_x), .ship_y(ship_y), .ship_dir(ship_dir), .kill_mask(kill_mask), .shots(shots_l),
    .fire_ack(ack_l), .fire_drop(drop_l), .shot_count(cnt_l));
  shot_manager #(.SHOT_TTL(3)) dut_s (.move_clk(move_clk), .reset_n(reset_n), .fire_req(fire_req),
    .ship_x(ship_x), .ship_y(ship_y), .ship_dir(ship_dir), .kill_mask(kill_mask), .shots(shots_s),
    .fire_ack(ack_s), .fire_drop(drop_s), .shot_count(cnt_s));

  always #5 move_clk = ~move_clk;

  function automatic logic [33:0] slot(input logic [339:0] v, input int i);
    return v[i*34 +: 34];
  endfunction
  function automatic logic [33:0] mk(input int x, input int y, input int d, input int t);
    return {1'b1, 10'(x), 10'(y), 6'(d), 7'(t)};
  endfunction

  task automatic tick;
    @(posedge move_clk);
    #1;
  endtask
  task automatic do_reset;
    reset_n = 1'b1;
    fire_req = 1'b0;
    kill_mask = '0;
    tick();
    reset_n = 1'b0;
  endtask
  task automatic spawn_one(input int x, input int y, input int d);
    do_reset();
    ship_x = 10'(x);
    ship_y = 10'(y);
    ship_dir = 6'(d);
    fire_req = 1'b1;
    tick();
    fire_req = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b1;
    tick();
    checks++; if (shots_a !== '0) begin failures++; $display("FAIL reset_shots got=%h exp=0", shots_a); end
    checks++; if (cnt_a !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", cnt_a); end
    checks++; if (ack_a !== 1'b0 || drop_a !== 1'b0) begin failures++; $display("FAIL reset_pulses ack=%b drop=%b exp=0", ack_a, drop_a); end
  endtask

  task automatic test_spawn_move;
    spawn_one(100, 50, 0);
    checks++; if (slot(shots_a, 0) !== mk(100, 50, 0, 90)) begin failures++; $display("FAIL spawn_word got=%h exp=%h", slot(shots_a, 0), mk(100, 50, 0, 90)); end
    checks++; if (ack_a !== 1'b1) begin failures++; $display("FAIL spawn_ack got=%b exp=1", ack_a); end
    checks++; if (cnt_a !== 4'd1) begin failures++; $display("FAIL spawn_count got=%0d exp=1", cnt_a); end
    tick();
    checks++; if (slot(shots_a, 0) !== mk(100, 48, 0, 89)) begin failures++; $display("FAIL first_move got=%h exp=%h", slot(shots_a, 0), mk(100, 48, 0, 89)); end
    checks++; if (ack_a !== 1'b0) begin failures++; $display("FAIL ack_pulse_width got=%b exp=0", ack_a); end
  endtask

  task automatic test_wrap;
    spawn_one(319, 100, 16);
    tick();
    checks++; if (slot(shots_a, 0) !== mk(1, 100, 16, 89)) begin failures++; $display("FAIL wrap_x got=%h exp=%h", slot(shots_a, 0), mk(1, 100, 16, 89)); end
    spawn_one(200, 0, 0);
    tick();
    checks++; if (slot(shots_a, 0) !== mk(200, 238, 0, 89)) begin failures++; $display("FAIL wrap_y got=%h exp=%h", slot(shots_a, 0), mk(200, 238, 0, 89)); end
    spawn_one(10, 10, 8);
    tick();
    checks++; if (slot(shots_a, 0) !== mk(11, 9, 8, 89)) begin failures++; $display("FAIL diag_8 got=%h exp=%h", slot(shots_a, 0), mk(11, 9, 8, 89)); end
    spawn_one(0, 239, 40);
    tick();
    checks++; if (slot(shots_a, 0) !== mk(319, 0, 40, 89)) begin failures++; $display("FAIL diag_wrap got=%h exp=%h", slot(shots_a, 0), mk(319, 0, 40, 89)); end
  endtask

  task automatic test_cooldown;
    do_reset();
    ship_x = 10'd160;
    ship_y = 10'd120;
    ship_dir = 6'd0;
    fire_req = 1'b1;
    for (int t = 0; t < 40; t++) begin
      tick();
      checks++; if (ack_a !== (t % 9 == 0)) begin failures++; $display("FAIL cooldown_ack t=%0d got=%b exp=%b", t, ack_a, t % 9 == 0); end
    end
    fire_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++; if (slot(shots_a, k) !== mk(160, 120 - 2 * (39 - 9 * k), 0, 90 - (39 - 9 * k))) begin failures++; $display("FAIL held_slot%0d got=%h exp=%h", k, slot(shots_a, k), mk(160, 120 - 2 * (39 - 9 * k), 0, 90 - (39 - 9 * k))); end
    end
    checks++; if (slot(shots_a, 5) !== '0) begin failures++; $display("FAIL held_slot5 got=%h exp=0", slot(shots_a, 5)); end
    checks++; if (cnt_a !== 4'd5) begin failures++; $display("FAIL held_count got=%0d exp=5", cnt_a); end
  endtask

  task automatic test_full_drop;
    do_reset();
    ship_x = 10'd160;
    ship_y = 10'd120;
    ship_dir = 6'd0;
    fire_req = 1'b1;
    repeat (90) tick();
    checks++; if (cnt_l !== 4'd10) begin failures++; $display("FAIL full_count got=%0d exp=10", cnt_l); end
    tick();
    checks++; if (drop_l !== 1'b1 || ack_l !== 1'b0) begin failures++; $display("FAIL full_drop drop=%b ack=%b exp=1/0", drop_l, ack_l); end
    checks++; if (cnt_l !== 4'd10) begin failures++; $display("FAIL drop_count got=%0d exp=10", cnt_l); end
    kill_mask = 10'b0000001000;
    tick();
    kill_mask = '0;
    checks++; if (drop_l !== 1'b1 || ack_l !== 1'b0) begin failures++; $display("FAIL kill_drop drop=%b ack=%b exp=1/0", drop_l, ack_l); end
    checks++; if (slot(shots_l, 3) !== '0 || cnt_l !== 4'd9) begin failures++; $display("FAIL kill_slot3 got=%h count=%0d exp=0/9", slot(shots_l, 3), cnt_l); end
    tick();
    fire_req = 1'b0;
    checks++; if (ack_l !== 1'b1 || drop_l !== 1'b0) begin failures++; $display("FAIL refill_ack ack=%b drop=%b exp=1/0", ack_l, drop_l); end
    checks++; if (slot(shots_l, 3) !== mk(160, 120, 0, 127) || cnt_l !== 4'd10) begin failures++; $display("FAIL refill_slot3 got=%h count=%0d exp=%h/10", slot(shots_l, 3), cnt_l, mk(160, 120, 0, 127)); end
  endtask

  task automatic test_ttl;
    spawn_one(50, 50, 16);
    checks++; if (slot(shots_s, 0) !== mk(50, 50, 16, 3) || cnt_s !== 4'd1) begin failures++; $display("FAIL ttl_spawn got=%h count=%0d", slot(shots_s, 0), cnt_s); end
    tick();
    checks++; if (slot(shots_s, 0) !== mk(52, 50, 16, 2)) begin failures++; $display("FAIL ttl_edge1 got=%h exp=%h", slot(shots_s, 0), mk(52, 50, 16, 2)); end
    tick();
    checks++; if (slot(shots_s, 0) !== mk(54, 50, 16, 1)) begin failures++; $display("FAIL ttl_edge2 got=%h exp=%h", slot(shots_s, 0), mk(54, 50, 16, 1)); end
    tick();
    checks++; if (slot(shots_s, 0) !== '0 || cnt_s !== 4'd0) begin failures++; $display("FAIL ttl_expire got=%h count=%0d exp=0/0", slot(shots_s, 0), cnt_s); end
  endtask

  task automatic test_async_reset;
    do_reset();
    ship_x = 10'd30;
    ship_y = 10'd40;
    ship_dir = 6'd32;
    fire_req = 1'b1;
    repeat (37) tick();
    checks++; if (cnt_a !== 4'd5) begin failures++; $display("FAIL pre_reset_count got=%0d exp=5", cnt_a); end
    #2 reset_n = 1'b1;
    #1;
    checks++; if (shots_a !== '0 || cnt_a !== 4'd0) begin failures++; $display("FAIL async_reset shots=%h count=%0d exp=0/0", shots_a, cnt_a); end
    #1 reset_n = 1'b0;
    tick();
    fire_req = 1'b0;
    checks++; if (slot(shots_a, 0) !== mk(30, 40, 32, 90) || ack_a !== 1'b1 || cnt_a !== 4'd1) begin failures++; $display("FAIL post_reset_spawn got=%h ack=%b count=%0d", slot(shots_a, 0), ack_a, cnt_a); end
  endtask

  initial begin
    test_reset();
    test_spawn_move();
    test_wrap();
    test_cooldown();
    test_full_drop();
    test_ttl();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
